ad2s1210_read_scheduler: RTL and testbench

// Arbitrates angle and speed read requests for one AD2S1210 resolver driver and

---
 rtl/ad2s1210_read_scheduler.sv | 145 ++++++++++++++
 tb/tb_ad2s1210_read_scheduler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ad2s1210_read_scheduler.sv
// Read scheduler for one AD2S1210 resolver driver: latches angle/speed requests,
// issues them one at a time (round-robin on ties) with an idle gap and a completion timeout.
module ad2s1210_read_scheduler #(
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 angle_req,
    input  logic                 speed_req,
    input  logic                 read_done,
    output logic                 read_angle,
    output logic                 read_speed,
    output logic                 busy,
    output logic                 timeout_flag,
    output logic [CNT_WIDTH-1:0] angle_overrun,
    output logic [CNT_WIDTH-1:0] speed_overrun,
    input  logic                 clear_status
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int CW = (TW > GW) ? TW : GW;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] GMAX = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   timer_reg, timer_next;
    logic            last_speed_reg, last_speed_next;   // 1 = last grant was speed
    logic            read_angle_reg, read_angle_next;
    logic            read_speed_reg, read_speed_next;
    logic            timeout_reg, timeout_next;
    logic            timeout_set;
    logic [1:0]      clr_pend;                           // bit 0 angle, bit 1 speed
    logic [1:0]      pend_reg;
    logic [1:0]      req;
    logic            grant_speed;
    logic [CNT_WIDTH-1:0] ovr_reg [2];

    assign req         = {speed_req, angle_req};
    // Speed wins when it is the only one pending, or on a tie after an angle grant.
    assign grant_speed = pend_reg[1] && (!pend_reg[0] || !last_speed_reg);

    always_comb begin
        state_next      = state_reg;
        timer_next      = timer_reg;
        last_speed_next = last_speed_reg;
        read_angle_next = 1'b0;
        read_speed_next = 1'b0;
        timeout_set     = 1'b0;
        clr_pend        = 2'b00;
        case (state_reg)
            IDLE: begin
                if (enable && (pend_reg != 2'b00)) begin
                    state_next      = ISSUE;
                    timer_next      = '0;
                    last_speed_next = grant_speed;
                    read_speed_next = grant_speed;
                    read_angle_next = !grant_speed;
                    clr_pend        = grant_speed ? 2'b10 : 2'b01;
                end
            end
            ISSUE: begin
                // The issue cycle counts toward the timeout window.
                state_next = WAIT;
                timer_next = timer_reg + CW'(1);
            end
            WAIT: begin
                if (read_done) begin
                    state_next = GAP;
                    timer_next = '0;
                end else if (timer_reg == TMAX) begin
                    state_next  = GAP;
                    timer_next  = '0;
                    timeout_set = 1'b1;
                end else begin
                    timer_next = timer_reg + CW'(1);
                end
            end
            GAP: begin
                if (timer_reg == GMAX) begin
                    state_next = IDLE;
                    timer_next = '0;
                end else begin
                    timer_next = timer_reg + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        timeout_next = clear_status ? 1'b0 : (timeout_reg | timeout_set);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            timer_reg      <= '0;
            last_speed_reg <= 1'b1;
            read_angle_reg <= 1'b0;
            read_speed_reg <= 1'b0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            last_speed_reg <= last_speed_next;
            read_angle_reg <= read_angle_next;
            read_speed_reg <= read_speed_next;
            timeout_reg    <= timeout_next;
        end
    end

    // Per-type pending latch and saturating overrun counter.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic pend_kept;
            logic ovr_inc;
            assign pend_kept = pend_reg[gi] && !clr_pend[gi];
            assign ovr_inc   = req[gi] && pend_kept;

            always_ff @(posedge clock) begin
                if (reset) begin
                    pend_reg[gi] <= 1'b0;
                    ovr_reg[gi]  <= '0;
                end else begin
                    pend_reg[gi] <= pend_kept || req[gi];
                    if (clear_status)
                        ovr_reg[gi] <= '0;
                    else if (ovr_inc && (ovr_reg[gi] != {CNT_WIDTH{1'b1}}))
                        ovr_reg[gi] <= ovr_reg[gi] + CNT_WIDTH'(1);
                end
            end
        end
    endgenerate

    assign read_angle    = read_angle_reg;
    assign read_speed    = read_speed_reg;
    assign busy          = (state_reg != IDLE);
    assign timeout_flag  = timeout_reg;
    assign angle_overrun = ovr_reg[0];
    assign speed_overrun = ovr_reg[1];

endmodule

// File: tb/tb_ad2s1210_read_scheduler.sv
// Directed bench for ad2s1210_read_scheduler: latency, round-robin, timeout,
// overrun saturation, enable gating and mid-read reset.
module tb_ad2s1210_read_scheduler;

    localparam int GAP = 4;
    localparam int TMO = 16;
    localparam int CW  = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic angle_req = 1'b0;
    logic speed_req = 1'b0;
    logic read_done = 1'b0;
    logic clear_status = 1'b0;
    logic read_angle, read_speed, busy, timeout_flag;
    logic [CW-1:0] angle_overrun, speed_overrun;

    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;
    int violations = 0;
    int snap;
    logic prev_pulse = 1'b0;

    ad2s1210_read_scheduler #(
        .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(CW)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .angle_req(angle_req), .speed_req(speed_req), .read_done(read_done),
        .read_angle(read_angle), .read_speed(read_speed), .busy(busy),
        .timeout_flag(timeout_flag), .angle_overrun(angle_overrun),
        .speed_overrun(speed_overrun), .clear_status(clear_status)
    );

    always #5 clock = ~clock;

    // Protocol watch: never both strobes, never strobes on consecutive cycles.
    always @(negedge clock) begin
        if (read_angle && read_speed) violations++;
        if (prev_pulse && (read_angle || read_speed)) violations++;
        if (read_angle || read_speed) pulses++;
        prev_pulse = read_angle || read_speed;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        reset = 1'b1; enable = 1'b0; angle_req = 1'b0; speed_req = 1'b0;
        read_done = 1'b0; clear_status = 1'b0;
        tick; tick;
        reset = 1'b0;
    endtask

    task automatic pulse_req(input logic a, input logic s);
        $display("request angle=%0d speed=%0d at %0t", a, s, $time);
        angle_req = a; speed_req = s;
        tick;
        angle_req = 1'b0; speed_req = 1'b0;
    endtask

    // From an ISSUE cycle: finish the read, run out the gap, expect the next issue.
    task automatic finish_and_expect(input string tag, input logic ea, input logic es);
        tick;
        read_done = 1'b1;
        tick;
        read_done = 1'b0;
        repeat (GAP) tick;
        check({tag, "_idle"}, busy, 0);
        tick;
        check({tag, "_a"}, read_angle, ea);
        check({tag, "_s"}, read_speed, es);
        $display("issue %s angle=%0d speed=%0d at %0t", tag, read_angle, read_speed, $time);
    endtask

    initial begin
        // Reset state
        do_reset;
        check("rst_read_angle", read_angle, 0);
        check("rst_read_speed", read_speed, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout_flag, 0);
        check("rst_aovr", angle_overrun, 0);
        check("rst_sovr", speed_overrun, 0);

        // Single angle read: latency, done, gap length
        enable = 1'b1;
        pulse_req(1'b1, 1'b0);
        check("t1_not_early", read_angle, 0);
        tick;
        check("t1_read_angle", read_angle, 1);
        check("t1_read_speed", read_speed, 0);
        check("t1_busy_issue", busy, 1);
        tick;
        check("t1_one_cycle", read_angle, 0);
        tick; tick;
        read_done = 1'b1;
        tick;
        read_done = 1'b0;
        repeat (GAP - 1) tick;
        check("t1_busy_gap_end", busy, 1);
        tick;
        check("t1_busy_low", busy, 0);
        check("t1_no_timeout", timeout_flag, 0);

        // Round-robin: A,S,A,S
        do_reset;
        enable = 1'b1;
        pulse_req(1'b1, 1'b1);
        tick;
        check("t2_a1_a", read_angle, 1);
        check("t2_a1_s", read_speed, 0);
        finish_and_expect("t2_s1", 1'b0, 1'b1);
        pulse_req(1'b1, 1'b1);
        finish_and_expect("t2_a2", 1'b1, 1'b0);
        finish_and_expect("t2_s2", 1'b0, 1'b1);
        tick;
        read_done = 1'b1;
        tick;
        read_done = 1'b0;
        repeat (GAP) tick;
        check("t2_idle_end", busy, 0);

        // Timeout exactly TMO cycles after issue
        do_reset;
        enable = 1'b1;
        pulse_req(1'b1, 1'b0);
        tick;
        check("t3_issue", read_angle, 1);
        repeat (TMO - 1) tick;
        check("t3_not_yet", timeout_flag, 0);
        check("t3_busy_wait", busy, 1);
        tick;
        check("t3_timeout", timeout_flag, 1);
        repeat (GAP - 1) tick;
        check("t3_busy_gap", busy, 1);
        tick;
        check("t3_idle", busy, 0);
        pulse_req(1'b0, 1'b1);
        tick;
        check("t3_next_speed", read_speed, 1);
        check("t3_sticky", timeout_flag, 1);
        tick;
        read_done = 1'b1;
        tick;
        read_done = 1'b0;
        repeat (GAP) tick;
        clear_status = 1'b1;
        tick;
        clear_status = 1'b0;
        check("t3_cleared", timeout_flag, 0);
        // read_done on the last timer cycle is a completion
        pulse_req(1'b1, 1'b0);
        tick;
        repeat (TMO - 1) tick;
        read_done = 1'b1;
        tick;
        read_done = 1'b0;
        check("t3_late_done_ok", timeout_flag, 0);
        check("t3_late_done_gap", busy, 1);
        repeat (GAP) tick;
        check("t3_late_idle", busy, 0);

        // Overruns
        do_reset;
        enable = 1'b1;
        pulse_req(1'b1, 1'b0);
        tick;
        tick;
        repeat (3) begin
            angle_req = 1'b1; tick;
            angle_req = 1'b0; tick;
        end
        check("t4_aovr_2", angle_overrun, 2);
        check("t4_sovr_0", speed_overrun, 0);
        finish_and_expect("t4_pend_a", 1'b1, 1'b0);
        tick;
        read_done = 1'b1;
        tick;
        read_done = 1'b0;
        repeat (GAP) tick;
        clear_status = 1'b1;
        tick;
        clear_status = 1'b0;
        check("t4_clear", angle_overrun, 0);
        enable = 1'b0;
        pulse_req(1'b1, 1'b0);
        check("t4_first_no_ovr", angle_overrun, 0);
        angle_req = 1'b1; clear_status = 1'b1;
        tick;
        angle_req = 1'b0; clear_status = 1'b0;
        check("t4_clear_wins", angle_overrun, 0);
        pulse_req(1'b1, 1'b0);
        check("t4_ovr_1", angle_overrun, 1);
        speed_req = 1'b1;
        repeat (3) tick;
        speed_req = 1'b0;
        check("t4_sovr_2", speed_overrun, 2);
        angle_req = 1'b1;
        repeat (66000) tick;
        angle_req = 1'b0;
        check("t4_saturate", angle_overrun, 65535);
        check("t4_sovr_hold", speed_overrun, 2);

        // Enable gating and reset mid-WAIT
        do_reset;
        pulse_req(1'b1, 1'b1);
        snap = pulses;
        repeat (10) tick;
        check("t5_held_pulses", pulses - snap, 0);
        check("t5_held_busy", busy, 0);
        enable = 1'b1;
        tick;
        check("t5_resume_a", read_angle, 1);
        tick;
        enable = 1'b0;
        read_done = 1'b1;
        tick;
        read_done = 1'b0;
        check("t5_inflight_done", busy, 1);
        repeat (GAP + 4) tick;
        check("t5_hold_speed", read_speed, 0);
        check("t5_hold_idle", busy, 0);
        pulse_req(1'b1, 1'b0);
        enable = 1'b1;
        tick;
        check("t5_speed_next", read_speed, 1);
        tick;
        reset = 1'b1;
        tick;
        check("t5_rst_busy", busy, 0);
        check("t5_rst_ra", read_angle, 0);
        check("t5_rst_rs", read_speed, 0);
        check("t5_rst_tmo", timeout_flag, 0);
        check("t5_rst_aovr", angle_overrun, 0);
        reset = 1'b0;
        snap = pulses;
        repeat (10) tick;
        check("t5_pend_cleared", pulses - snap, 0);
        check("t5_pend_idle", busy, 0);

        check("protocol", violations, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
